// File: rtl/player_lane_ctrl.sv
// rtl/player_lane_ctrl.sv - lane-stepping player sprite controller with erase/draw pixel stream
module player_lane_ctrl #(
  parameter int         NUM_LANES  = 4,
  parameter int         LANE_X0    = 14,
  parameter int         LANE_PITCH = 40,
  parameter int         Y_POS      = 99,
  parameter int         SPR_W      = 8,
  parameter int         SPR_H      = 8,
  parameter logic [2:0] COLOUR     = 3'b111
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         aP,
  input  logic                         dP,
  output logic [7:0]                   x_out,
  output logic [6:0]                   y_out,
  output logic [2:0]                   colour_out,
  output logic                         plot,
  output logic [$clog2(NUM_LANES)-1:0] lane_out,
  output logic                         busy
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANES - 1);
  localparam logic [3:0]    PX_LAST   = 4'(SPR_W - 1);
  localparam logic [3:0]    PY_LAST   = 4'(SPR_H - 1);

  if (NUM_LANES < 2 || NUM_LANES > 16 || SPR_W < 1 || SPR_W > 16 || SPR_H < 1 || SPR_H > 16 ||
      LANE_X0 + (NUM_LANES - 1) * LANE_PITCH + SPR_W - 1 > 159 || Y_POS + SPR_H - 1 > 119)
  begin : g_bad_geometry
    $fatal(1, "player_lane_ctrl: parameters place the sprite outside the 160x120 playfield");
  end

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ERASE, S_DRAW} state_t;

  state_t        state, next_state;
  logic [LW-1:0] lane, next_lane;
  logic [LW-1:0] target, next_target;
  logic [3:0]    px, next_px;
  logic [3:0]    py, next_py;
  logic          prev_a, prev_d;
  logic          req_valid, req_left, req_take;
  logic          rise_a, rise_d, new_req;
  logic          streaming;
  logic [7:0]    x_pix;
  logic [6:0]    y_pix;

  // Simultaneous left+right edges cancel out and leave any pending request untouched.
  assign rise_a  = aP & ~prev_a;
  assign rise_d  = dP & ~prev_d;
  assign new_req = rise_a ^ rise_d;

  assign streaming = (state == S_ERASE) || (state == S_DRAW);
  assign x_pix     = 8'(LANE_X0) + 8'(lane) * 8'(LANE_PITCH) + {4'd0, px};
  assign y_pix     = 7'(Y_POS) + {3'd0, py};
  assign lane_out  = lane;

  always_comb begin
    next_state  = state;
    next_lane   = lane;
    next_target = target;
    next_px     = px;
    next_py     = py;
    req_take    = 1'b0;
    case (state)
      S_INIT: next_state = S_DRAW;
      S_IDLE: begin
        if (req_valid) begin
          req_take = 1'b1;
          if (req_left && lane != '0) begin
            next_target = lane - LW'(1);
            next_state  = S_ERASE;
          end else if (!req_left && lane != LANE_LAST) begin
            next_target = lane + LW'(1);
            next_state  = S_ERASE;
          end
        end
      end
      S_ERASE, S_DRAW: begin
        if (px == PX_LAST && py == PY_LAST) begin
          if (state == S_ERASE) begin
            next_lane  = target;
            next_state = S_DRAW;
          end else begin
            next_state = S_IDLE;
          end
        end else if (px == PX_LAST) begin
          next_px = 4'd0;
          next_py = py + 4'd1;
        end else begin
          next_px = px + 4'd1;
        end
      end
      default: next_state = S_INIT;
    endcase
    if (next_state != state) begin
      next_px = 4'd0;
      next_py = 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_INIT;
      lane       <= '0;
      target     <= '0;
      px         <= 4'd0;
      py         <= 4'd0;
      prev_a     <= 1'b1;
      prev_d     <= 1'b1;
      req_valid  <= 1'b0;
      req_left   <= 1'b0;
      busy       <= 1'b0;
      plot       <= 1'b0;
      colour_out <= 3'd0;
      x_out      <= 8'(LANE_X0);
      y_out      <= 7'(Y_POS);
    end else begin
      state      <= next_state;
      lane       <= next_lane;
      target     <= next_target;
      px         <= next_px;
      py         <= next_py;
      prev_a     <= aP;
      prev_d     <= dP;
      // A fresh edge wins over the request being consumed this cycle.
      if (new_req) begin
        req_valid <= 1'b1;
        req_left  <= rise_a;
      end else if (req_take) begin
        req_valid <= 1'b0;
      end
      busy       <= (next_state == S_ERASE) || (next_state == S_DRAW);
      plot       <= streaming;
      colour_out <= (state == S_DRAW) ? COLOUR : 3'd0;
      x_out      <= x_pix;
      y_out      <= y_pix;
    end
  end

endmodule

// File: tb/tb_player_lane_ctrl.sv
// tb/tb_player_lane_ctrl.sv - directed self-checking bench for player_lane_ctrl
module tb_player_lane_ctrl;

  logic       clock = 1'b0;
  logic       resetn, aP, dP;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy;
  logic [1:0] lane_out;

  logic       resetn2, aP2, dP2;
  logic [7:0] x_out2;
  logic [6:0] y_out2;
  logic [2:0] colour_out2;
  logic       plot2, busy2;
  logic [2:0] lane_out2;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] rec_w  [400];
  logic [31:0] rec2_w [20];

  player_lane_ctrl u_dut (
    .clock(clock), .resetn(resetn), .aP(aP), .dP(dP),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .lane_out(lane_out), .busy(busy)
  );

  player_lane_ctrl #(.NUM_LANES(8), .LANE_PITCH(18), .SPR_W(3), .SPR_H(2)) u_dut2 (
    .clock(clock), .resetn(resetn2), .aP(aP2), .dP(dP2),
    .x_out(x_out2), .y_out(y_out2), .colour_out(colour_out2),
    .plot(plot2), .lane_out(lane_out2), .busy(busy2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int x, input int y, input int c, input int p);
    return {13'd0, 8'(x), 7'(y), 3'(c), 1'(p)};
  endfunction

  function automatic logic [31:0] dut_word();
    return {13'd0, x_out, y_out, colour_out, plot};
  endfunction

  function automatic logic [31:0] dut2_word();
    return {13'd0, x_out2, y_out2, colour_out2, plot2};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(plot), 32'd0);
    end
  endtask

  // Outputs currently show pixel 0; leaves outputs at the cycle after the last pixel.
  task automatic expect_stream(input string tag, input int n, input int x0, input int y0,
                               input int col);
    for (int i = 0; i < n; i++) begin
      check(tag, dut_word(), pix(x0 + i % 8, y0 + i / 8, col, 1));
      if (i == 0) check({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; aP = 1'b0; dP = 1'b1;
    resetn2 = 1'b0; aP2 = 1'b0; dP2 = 1'b0;
    repeat (3) tick();
    check("reset_outputs", dut_word(), pix(14, 99, 0, 0));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_lane", 32'(lane_out), 32'd0);

    // Release with dP held high: it must not be taken as a press.
    resetn = 1'b1;
    quiet("init_latency", 1);
    tick();
    expect_stream("init_draw", 64, 14, 99, 7);
    check("init_post_plot", 32'(plot), 32'd0);
    check("init_post_busy", 32'(busy), 32'd0);
    quiet("held_thru_reset", 10);
    check("held_thru_reset_lane", 32'(lane_out), 32'd0);
    dP = 1'b0;
    tick();

    aP = 1'b1; tick(); aP = 1'b0;
    quiet("left_at_0", 10);
    check("left_at_0_lane", 32'(lane_out), 32'd0);

    dP = 1'b1; tick(); check("move01_lat1", 32'(plot), 32'd0);
    dP = 1'b0; tick(); check("move01_lat2", 32'(plot), 32'd0);
    tick();
    expect_stream("move01_erase", 64, 14, 99, 0);
    expect_stream("move01_draw", 64, 54, 99, 7);
    check("move01_post_plot", 32'(plot), 32'd0);
    check("move01_lane", 32'(lane_out), 32'd1);

    dP = 1'b1; tick(); tick(); tick();
    expect_stream("move12_erase", 64, 54, 99, 0);
    expect_stream("move12_draw", 64, 94, 99, 7);
    quiet("held_no_repeat", 20);
    check("move12_lane", 32'(lane_out), 32'd2);
    dP = 1'b0; tick();

    dP = 1'b1; tick(); dP = 1'b0; tick(); tick();
    expect_stream("move23_erase", 64, 94, 99, 0);
    expect_stream("move23_draw", 64, 134, 99, 7);
    check("move23_lane", 32'(lane_out), 32'd3);

    dP = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (plot) cnt++;
    end
    check("held_right_at_3_plots", 32'(cnt), 32'd0);
    check("held_right_at_3_lane", 32'(lane_out), 32'd3);
    dP = 1'b0; tick();

    aP = 1'b1; tick(); aP = 1'b0; tick(); tick();
    expect_stream("abort_erase", 29, 134, 99, 0);
    check("abort_pix30", dut_word(), pix(139, 102, 0, 1));
    resetn = 1'b0; tick();
    check("abort_reset_outputs", dut_word(), pix(14, 99, 0, 0));
    check("abort_reset_busy", 32'(busy), 32'd0);
    check("abort_reset_lane", 32'(lane_out), 32'd0);
    resetn = 1'b1; tick();
    check("abort_redraw_lat", 32'(plot), 32'd0);
    tick();
    expect_stream("abort_redraw", 64, 14, 99, 7);
    check("abort_redraw_post", 32'(plot), 32'd0);

    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      dP = (c == 0 || c == 10 || c == 20 || c == 30);
      aP = (c == 30);
      tick();
      rec_w[c] = dut_word();
      if (plot) cnt++;
    end
    aP = 1'b0; dP = 1'b0;
    check("queue_plot_count", 32'(cnt), 32'd256);
    check("queue_pre", 32'(rec_w[1][0]), 32'd0);
    check("queue_erase1_first", rec_w[2], pix(14, 99, 0, 1));
    check("queue_erase1_last", rec_w[65], pix(21, 106, 0, 1));
    check("queue_draw1_first", rec_w[66], pix(54, 99, 7, 1));
    check("queue_draw1_last", rec_w[129], pix(61, 106, 7, 1));
    check("queue_idle_gap", 32'(rec_w[130][0]), 32'd0);
    check("queue_erase2_first", rec_w[131], pix(54, 99, 0, 1));
    check("queue_draw2_first", rec_w[195], pix(94, 99, 7, 1));
    check("queue_draw2_last", rec_w[258], pix(101, 106, 7, 1));
    check("queue_post", 32'(rec_w[259][0]), 32'd0);
    check("queue_lane", 32'(lane_out), 32'd2);

    resetn2 = 1'b1;
    repeat (20) tick();
    check("p2_init_lane", 32'(lane_out2), 32'd0);
    for (int p = 0; p < 6; p++) begin
      dP2 = 1'b1; tick(); dP2 = 1'b0;
      repeat (19) tick();
    end
    check("p2_lane6", 32'(lane_out2), 32'd6);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      dP2 = (c == 0);
      tick();
      rec2_w[c] = dut2_word();
      if (plot2) cnt++;
    end
    dP2 = 1'b0;
    check("p2_plot_count", 32'(cnt), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < 6) check("p2_erase", rec2_w[2 + i], pix(122 + i % 3, 99 + i / 3, 0, 1));
      else       check("p2_draw", rec2_w[2 + i], pix(140 + (i - 6) % 3, 99 + (i - 6) / 3, 7, 1));
    end
    check("p2_lane7", 32'(lane_out2), 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
